// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the 64-bit data memory between the core and loader ports.
// One request in flight: accept, memory strobe next cycle, one-cycle response after that.
module dmem_arbiter #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IW    = 10
) (
  input  logic          clock,
  input  logic          reset,

  input  logic          cpu_req_valid,
  output logic          cpu_req_ready,
  input  logic          cpu_req_write,
  input  logic [63:0]   cpu_req_addr,
  input  logic [63:0]   cpu_req_wdata,
  output logic          cpu_resp_valid,
  output logic [63:0]   cpu_resp_rdata,
  output logic          cpu_resp_err,

  input  logic          ld_req_valid,
  output logic          ld_req_ready,
  input  logic          ld_req_write,
  input  logic [63:0]   ld_req_addr,
  input  logic [63:0]   ld_req_wdata,
  output logic          ld_resp_valid,
  output logic [63:0]   ld_resp_rdata,
  output logic          ld_resp_err,

  output logic          mem_en,
  output logic          mem_we,
  output logic [IW-1:0] mem_index,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_ld_q, last_ld_d;
  logic        port_ld_q, port_ld_d;
  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        cpu_resp_q, cpu_resp_d;
  logic        ld_resp_q, ld_resp_d;
  logic        err_q, err_d;
  logic        rd_ok_q, rd_ok_d;

  logic        grant_cpu, grant_ld;
  logic        cpu_hs, ld_hs;
  logic        req_err;

  // On a tie the port that did not win last time is granted.
  assign grant_cpu = cpu_req_valid & (~ld_req_valid | last_ld_q);
  assign grant_ld  = ld_req_valid & (~cpu_req_valid | ~last_ld_q);

  // Readys are forced low during reset so every output reads 0 while it is held.
  assign cpu_req_ready = (state_q == StIdle) & grant_cpu & ~reset;
  assign ld_req_ready  = (state_q == StIdle) & grant_ld & ~reset;
  assign cpu_hs        = cpu_req_valid & cpu_req_ready;
  assign ld_hs         = ld_req_valid & ld_req_ready;

  assign req_err = (addr_q[2:0] != 3'b000) || ((addr_q >> 3) >= 64'(DEPTH));

  assign mem_en    = (state_q == StIssue) & ~req_err;
  assign mem_we    = mem_en & write_q;
  assign mem_index = mem_en ? addr_q[IW+2:3] : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;

  assign cpu_resp_valid = cpu_resp_q;
  assign cpu_resp_err   = cpu_resp_q & err_q;
  assign cpu_resp_rdata = (cpu_resp_q & rd_ok_q) ? mem_rdata : '0;
  assign ld_resp_valid  = ld_resp_q;
  assign ld_resp_err    = ld_resp_q & err_q;
  assign ld_resp_rdata  = (ld_resp_q & rd_ok_q) ? mem_rdata : '0;

  always_comb begin
    state_d    = state_q;
    last_ld_d  = last_ld_q;
    port_ld_d  = port_ld_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cpu_resp_d = 1'b0;
    ld_resp_d  = 1'b0;
    err_d      = 1'b0;
    rd_ok_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpu_hs || ld_hs) begin
          port_ld_d = ld_hs;
          last_ld_d = ld_hs;
          write_d   = ld_hs ? ld_req_write : cpu_req_write;
          addr_d    = ld_hs ? ld_req_addr : cpu_req_addr;
          wdata_d   = ld_hs ? ld_req_wdata : cpu_req_wdata;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        cpu_resp_d = ~port_ld_q;
        ld_resp_d  = port_ld_q;
        err_d      = req_err;
        rd_ok_d    = ~req_err & ~write_q;
        state_d    = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      last_ld_q  <= 1'b1;
      port_ld_q  <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_resp_q <= 1'b0;
      ld_resp_q  <= 1'b0;
      err_q      <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_ld_q  <= last_ld_d;
      port_ld_q  <= port_ld_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_resp_q <= cpu_resp_d;
      ld_resp_q  <= ld_resp_d;
      err_q      <= err_d;
      rd_ok_q    <= rd_ok_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of arbitration, address checking and memory contents.
module tb_dmem_arbiter;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned IW    = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req_valid, cpu_req_ready, cpu_req_write;
  logic [63:0]   cpu_req_addr, cpu_req_wdata;
  logic          cpu_resp_valid, cpu_resp_err;
  logic [63:0]   cpu_resp_rdata;
  logic          ld_req_valid, ld_req_ready, ld_req_write;
  logic [63:0]   ld_req_addr, ld_req_wdata;
  logic          ld_resp_valid, ld_resp_err;
  logic [63:0]   ld_resp_rdata;
  logic          mem_en, mem_we;
  logic [IW-1:0] mem_index;
  logic [63:0]   mem_wdata, mem_rdata;

  int checks = 0;
  int fails  = 0;

  logic [63:0]   dut_mem [DEPTH];
  logic [63:0]   ref_mem [DEPTH];
  logic          pre_we = 1'b0;
  logic [IW-1:0] pre_idx;
  logic [63:0]   pre_data;

  dmem_arbiter #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clock          (clock),
    .reset          (reset),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_write  (cpu_req_write),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_rdata (cpu_resp_rdata),
    .cpu_resp_err   (cpu_resp_err),
    .ld_req_valid   (ld_req_valid),
    .ld_req_ready   (ld_req_ready),
    .ld_req_write   (ld_req_write),
    .ld_req_addr    (ld_req_addr),
    .ld_req_wdata   (ld_req_wdata),
    .ld_resp_valid  (ld_resp_valid),
    .ld_resp_rdata  (ld_resp_rdata),
    .ld_resp_err    (ld_resp_err),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_index      (mem_index),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous-read memory array with a bench-only preload port.
  always @(posedge clock) begin
    if (pre_we) dut_mem[pre_idx] <= pre_data;
    else if (mem_en && mem_we) dut_mem[mem_index] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= dut_mem[mem_index];
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive_port(input logic is_ld, input logic v, input logic w,
                            input logic [63:0] a, input logic [63:0] d);
    if (is_ld) begin
      ld_req_valid = v; ld_req_write = w; ld_req_addr = a; ld_req_wdata = d;
    end else begin
      cpu_req_valid = v; cpu_req_write = w; cpu_req_addr = a; cpu_req_wdata = d;
    end
  endtask

  // Runs one isolated request from IDLE and returns what the DUT showed at T, T+1, T+2.
  task automatic run_req(input logic is_ld, input logic w, input logic [63:0] a,
                         input logic [63:0] d, output logic rdy, output logic en,
                         output logic we, output logic [IW-1:0] idx, output logic [63:0] wd,
                         output logic rv, output logic err, output logic [63:0] rd,
                         output logic other_rv);
    drive_port(is_ld, 1'b1, w, a, d);
    @(negedge clock);
    rdy = is_ld ? ld_req_ready : cpu_req_ready;
    tick;
    drive_port(is_ld, 1'b0, ~w, ~a, ~d);  // fields must already be latched
    @(negedge clock);
    en = mem_en; we = mem_we; idx = mem_index; wd = mem_wdata;
    tick;
    @(negedge clock);
    rv       = is_ld ? ld_resp_valid : cpu_resp_valid;
    err      = is_ld ? ld_resp_err : cpu_resp_err;
    rd       = is_ld ? ld_resp_rdata : cpu_resp_rdata;
    other_rv = is_ld ? cpu_resp_valid : ld_resp_valid;
    tick;
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] w;
    w = 64'($urandom_range(0, 31));
    case ($urandom_range(0, 9))
      0: return (w << 3) | 64'($urandom_range(1, 7));
      1: return (64'(DEPTH) + 64'($urandom_range(0, 7))) << 3;
      2: return {32'($urandom_range(1, 255)), 32'(w << 3)};
      3: return 64'(DEPTH - 1) << 3;
      default: return w << 3;
    endcase
  endfunction

  task automatic test_reset;
    cpu_req_valid = 1'b1;
    ld_req_valid  = 1'b1;
    #1;
    checks++; if (cpu_req_ready !== 1'b0 || ld_req_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready got=%b%b exp=00", cpu_req_ready, ld_req_ready); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_index !== '0 || mem_wdata !== '0)
      begin fails++; $display("FAIL reset_mem got en=%b we=%b idx=%0h wd=%0h exp 0",
        mem_en, mem_we, mem_index, mem_wdata); end
    checks++; if (cpu_resp_valid !== 1'b0 || cpu_resp_err !== 1'b0 || cpu_resp_rdata !== '0)
      begin fails++; $display("FAIL reset_cpu_resp got v=%b e=%b d=%0h exp 0",
        cpu_resp_valid, cpu_resp_err, cpu_resp_rdata); end
    checks++; if (ld_resp_valid !== 1'b0 || ld_resp_err !== 1'b0 || ld_resp_rdata !== '0)
      begin fails++; $display("FAIL reset_ld_resp got v=%b e=%b d=%0h exp 0",
        ld_resp_valid, ld_resp_err, ld_resp_rdata); end
    cpu_req_valid = 1'b0;
    ld_req_valid  = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (cpu_req_ready !== 1'b0 || ld_req_ready !== 1'b0) begin
      fails++; $display("FAIL idle_no_valid got=%b%b exp=00", cpu_req_ready, ld_req_ready); end
    tick;
  endtask

  task automatic test_store_load;
    logic rdy, en, we, rv, err, orv;
    logic [IW-1:0] idx;
    logic [63:0] wd, rd;
    run_req(1'b0, 1'b1, 64'h10, 64'hDEAD, rdy, en, we, idx, wd, rv, err, rd, orv);
    ref_mem[2] = 64'hDEAD;
    checks++; if (rdy !== 1'b1) begin fails++; $display("FAIL st_ready got=%b exp=1", rdy); end
    checks++; if (en !== 1'b1 || we !== 1'b1) begin
      fails++; $display("FAIL st_strobe got en=%b we=%b exp 1 1", en, we); end
    checks++; if (idx !== 10'd2 || wd !== 64'hDEAD) begin
      fails++; $display("FAIL st_index got idx=%0d wd=%0h exp 2 dead", idx, wd); end
    checks++; if (rv !== 1'b1 || err !== 1'b0 || rd !== '0 || orv !== 1'b0) begin
      fails++; $display("FAIL st_resp got v=%b e=%b d=%0h o=%b exp 1 0 0 0", rv, err, rd, orv);
    end
    checks++; if (cpu_resp_valid !== 1'b0) begin
      fails++; $display("FAIL st_resp_drop got=%b exp=0", cpu_resp_valid); end
    run_req(1'b0, 1'b0, 64'h10, 64'h0, rdy, en, we, idx, wd, rv, err, rd, orv);
    checks++; if (en !== 1'b1 || we !== 1'b0 || idx !== 10'd2) begin
      fails++; $display("FAIL ld_strobe got en=%b we=%b idx=%0d exp 1 0 2", en, we, idx); end
    checks++; if (rv !== 1'b1 || err !== 1'b0 || rd !== 64'hDEAD) begin
      fails++; $display("FAIL load_resp got v=%b e=%b d=%0h exp 1 0 dead", rv, err, rd); end
  endtask

  task automatic test_errors;
    logic rdy, en, we, rv, err, orv;
    logic [IW-1:0] idx;
    logic [63:0] wd, rd;
    run_req(1'b1, 1'b0, 64'h0C, 64'h0, rdy, en, we, idx, wd, rv, err, rd, orv);
    checks++; if (rdy !== 1'b1 || en !== 1'b0) begin
      fails++; $display("FAIL misalign_en got rdy=%b en=%b exp 1 0", rdy, en); end
    checks++; if (rv !== 1'b1 || err !== 1'b1 || rd !== '0 || orv !== 1'b0) begin
      fails++; $display("FAIL misalign_resp got v=%b e=%b d=%0h o=%b exp 1 1 0 0",
        rv, err, rd, orv); end
    run_req(1'b0, 1'b0, 64'h2000, 64'h0, rdy, en, we, idx, wd, rv, err, rd, orv);
    checks++; if (en !== 1'b0 || rv !== 1'b1 || err !== 1'b1 || rd !== '0) begin
      fails++; $display("FAIL range_1024 got en=%b v=%b e=%b d=%0h exp 0 1 1 0", en, rv, err, rd);
    end
    run_req(1'b0, 1'b0, 64'h1FF8, 64'h0, rdy, en, we, idx, wd, rv, err, rd, orv);
    checks++; if (en !== 1'b1 || idx !== 10'd1023) begin
      fails++; $display("FAIL range_1023_strobe got en=%b idx=%0d exp 1 1023", en, idx); end
    checks++; if (rv !== 1'b1 || err !== 1'b0 || rd !== ref_mem[1023]) begin
      fails++; $display("FAIL range_1023_resp got v=%b e=%b d=%0h exp 1 0 %0h",
        rv, err, rd, ref_mem[1023]); end
    run_req(1'b0, 1'b0, 64'h8000_0000_0000_0010, 64'h0, rdy, en, we, idx, wd, rv, err, rd, orv);
    checks++; if (en !== 1'b0 || err !== 1'b1) begin
      fails++; $display("FAIL high_addr got en=%b e=%b exp 0 1", en, err); end
  endtask

  task automatic test_ld_during_cpu;
    drive_port(1'b0, 1'b1, 1'b0, 64'h18, 64'h0);
    @(negedge clock);
    checks++; if (cpu_req_ready !== 1'b1) begin
      fails++; $display("FAIL busy_cpu_ready got=%b exp=1", cpu_req_ready); end
    tick;
    drive_port(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    drive_port(1'b1, 1'b1, 1'b0, 64'h20, 64'h0);
    @(negedge clock);
    checks++; if (ld_req_ready !== 1'b0) begin
      fails++; $display("FAIL busy_issue_ld_ready got=%b exp=0", ld_req_ready); end
    tick;
    @(negedge clock);
    checks++; if (ld_req_ready !== 1'b0 || cpu_resp_valid !== 1'b1) begin
      fails++; $display("FAIL busy_resp got ldrdy=%b cpuv=%b exp 0 1", ld_req_ready,
        cpu_resp_valid); end
    checks++; if (cpu_resp_rdata !== ref_mem[3]) begin
      fails++; $display("FAIL busy_cpu_rdata got=%0h exp=%0h", cpu_resp_rdata, ref_mem[3]); end
    tick;
    @(negedge clock);
    checks++; if (ld_req_ready !== 1'b1) begin
      fails++; $display("FAIL busy_idle_ld_ready got=%b exp=1", ld_req_ready); end
    tick;
    drive_port(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
    @(negedge clock);
    checks++; if (mem_en !== 1'b1 || mem_index !== 10'd4) begin
      fails++; $display("FAIL busy_ld_strobe got en=%b idx=%0d exp 1 4", mem_en, mem_index); end
    tick;
    @(negedge clock);
    checks++; if (ld_resp_valid !== 1'b1 || ld_resp_rdata !== ref_mem[4]) begin
      fails++; $display("FAIL busy_ld_resp got v=%b d=%0h exp 1 %0h", ld_resp_valid,
        ld_resp_rdata, ref_mem[4]); end
    tick;
  endtask

  task automatic test_reset_mid;
    drive_port(1'b0, 1'b1, 1'b0, 64'h28, 64'h0);
    @(negedge clock);
    tick;
    drive_port(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    checks++; if (mem_en !== 1'b1) begin
      fails++; $display("FAIL rmid_issue_en got=%b exp=1", mem_en); end
    drive_port(1'b1, 1'b1, 1'b0, 64'h30, 64'h0);
    reset = 1'b1;
    #1;
    checks++; if (mem_en !== 1'b0 || mem_index !== '0 || ld_req_ready !== 1'b0) begin
      fails++; $display("FAIL rmid_outputs got en=%b idx=%0d ldrdy=%b exp 0 0 0", mem_en,
        mem_index, ld_req_ready); end
    checks++; if (cpu_resp_valid !== 1'b0 || cpu_req_ready !== 1'b0) begin
      fails++; $display("FAIL rmid_cpu got v=%b rdy=%b exp 0 0", cpu_resp_valid, cpu_req_ready);
    end
    tick;
    reset = 1'b0;
    #1;
    checks++; if (ld_req_ready !== 1'b1 || cpu_req_ready !== 1'b0) begin
      fails++; $display("FAIL rmid_ld_alone got ld=%b cpu=%b exp 1 0", ld_req_ready,
        cpu_req_ready); end
    @(negedge clock);
    #1;
    drive_port(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++; if (cpu_resp_valid !== 1'b0 || ld_resp_valid !== 1'b0 || mem_en !== 1'b0) begin
        fails++; $display("FAIL rmid_quiet%0d got cv=%b lv=%b en=%b exp 0 0 0", i,
          cpu_resp_valid, ld_resp_valid, mem_en); end
    end
    drive_port(1'b0, 1'b1, 1'b0, 64'h0, 64'h0);
    drive_port(1'b1, 1'b1, 1'b0, 64'h0, 64'h0);
    #1;
    checks++; if (cpu_req_ready !== 1'b1 || ld_req_ready !== 1'b0) begin
      fails++; $display("FAIL rmid_tie got cpu=%b ld=%b exp 1 0", cpu_req_ready, ld_req_ready);
    end
    drive_port(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    drive_port(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
    tick;
  endtask

  task automatic test_contention;
    int   ng = 0;
    int   c  = 0;
    int   gc[4];
    logic gl[4];
    reset = 1'b1;
    tick;
    reset = 1'b0;
    drive_port(1'b0, 1'b1, 1'b0, 64'h00, 64'h0);
    drive_port(1'b1, 1'b1, 1'b0, 64'h08, 64'h0);
    while (ng < 4 && c < 20) begin
      @(negedge clock);
      checks++; if (cpu_req_ready && ld_req_ready) begin
        fails++; $display("FAIL rr_both_ready cycle=%0d got=11 exp one-hot", c); end
      if (cpu_req_ready || ld_req_ready) begin
        gc[ng] = c;
        gl[ng] = ld_req_ready;
        ng++;
      end
      tick;
      c++;
    end
    drive_port(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    drive_port(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
    checks++; if (ng !== 4) begin
      fails++; $display("FAIL rr_grant_count got=%0d exp=4", ng); end
    for (int i = 0; i < ng; i++) begin
      checks++; if (gl[i] !== logic'(i % 2) || (gc[i] - gc[0]) !== 3 * i) begin
        fails++; $display("FAIL rr_grant%0d got ld=%b dt=%0d exp ld=%0d dt=%0d", i, gl[i],
          gc[i] - gc[0], i % 2, 3 * i); end
    end
    repeat (3) tick;
  endtask

  task automatic test_random;
    logic        c_v = 1'b0, l_v = 1'b0, c_w = 1'b0, l_w = 1'b0;
    logic [63:0] c_a = '0, c_d = '0, l_a = '0, l_d = '0, a;
    int          phase = 0;
    int          naccept = 0;
    logic        last_ld = 1'b1;
    logic        cur_ld = 1'b0, cur_w = 1'b0, cur_err = 1'b0;
    logic [IW-1:0] cur_idx = '0;
    logic [63:0] cur_d = '0, cur_rd = '0;
    logic        e_crdy, e_lrdy, e_en, e_cv, e_lv;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int n = 0; n < 900; n++) begin
      if (!c_v) begin
        if ($urandom_range(0, 1) == 1) begin
          c_v = 1'b1; c_w = 1'($urandom_range(0, 1)); c_a = rand_addr();
          c_d = {$urandom, $urandom};
        end
      end else if ($urandom_range(0, 7) == 0) c_v = 1'b0;
      if (!l_v) begin
        if ($urandom_range(0, 1) == 1) begin
          l_v = 1'b1; l_w = 1'($urandom_range(0, 1)); l_a = rand_addr();
          l_d = {$urandom, $urandom};
        end
      end else if ($urandom_range(0, 7) == 0) l_v = 1'b0;
      drive_port(1'b0, c_v, c_w, c_a, c_d);
      drive_port(1'b1, l_v, l_w, l_a, l_d);
      @(negedge clock);
      e_crdy = (phase == 0) && c_v && (!l_v || last_ld);
      e_lrdy = (phase == 0) && l_v && (!c_v || !last_ld);
      e_en   = (phase == 1) && !cur_err;
      e_cv   = (phase == 2) && !cur_ld;
      e_lv   = (phase == 2) && cur_ld;
      checks++; if (cpu_req_ready !== e_crdy || ld_req_ready !== e_lrdy) begin
        fails++; $display("FAIL rnd_ready n=%0d got=%b%b exp=%b%b", n, cpu_req_ready,
          ld_req_ready, e_crdy, e_lrdy); end
      checks++; if (mem_en !== e_en) begin
        fails++; $display("FAIL rnd_mem_en n=%0d got=%b exp=%b", n, mem_en, e_en); end
      if (e_en) begin
        checks++; if (mem_we !== cur_w || mem_index !== cur_idx ||
                      (cur_w && mem_wdata !== cur_d)) begin
          fails++; $display("FAIL rnd_mem_port n=%0d got we=%b idx=%0d wd=%0h exp %b %0d %0h",
            n, mem_we, mem_index, mem_wdata, cur_w, cur_idx, cur_d); end
      end
      checks++; if (cpu_resp_valid !== e_cv || ld_resp_valid !== e_lv) begin
        fails++; $display("FAIL rnd_resp_valid n=%0d got=%b%b exp=%b%b", n, cpu_resp_valid,
          ld_resp_valid, e_cv, e_lv); end
      checks++; if (cpu_resp_err !== (e_cv && cur_err) || ld_resp_err !== (e_lv && cur_err))
        begin fails++; $display("FAIL rnd_resp_err n=%0d got=%b%b exp=%b%b", n, cpu_resp_err,
          ld_resp_err, e_cv && cur_err, e_lv && cur_err); end
      checks++; if (cpu_resp_rdata !== (e_cv ? cur_rd : 64'h0) ||
                    ld_resp_rdata !== (e_lv ? cur_rd : 64'h0)) begin
        fails++; $display("FAIL rnd_rdata n=%0d got cpu=%0h ld=%0h exp %0h on %s", n,
          cpu_resp_rdata, ld_resp_rdata, cur_rd, cur_ld ? "ld" : "cpu"); end
      if (phase == 2) phase = 0;
      else if (phase == 1) phase = 2;
      else if (e_crdy || e_lrdy) begin
        cur_ld  = e_lrdy;
        a       = cur_ld ? l_a : c_a;
        cur_w   = cur_ld ? l_w : c_w;
        cur_d   = cur_ld ? l_d : c_d;
        cur_err = (a % 8 != 0) || ((a / 8) >= 64'(DEPTH));
        cur_idx = IW'(a / 8);
        cur_rd  = (!cur_w && !cur_err) ? ref_mem[cur_idx] : 64'h0;
        if (cur_w && !cur_err) ref_mem[cur_idx] = cur_d;
        last_ld = cur_ld;
        phase   = 1;
        naccept++;
        if (cur_ld) l_v = 1'b0;
        else c_v = 1'b0;
      end
      tick;
    end
    drive_port(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    drive_port(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
    repeat (3) tick;
    checks++; if (naccept < 150) begin
      fails++; $display("FAIL rnd_progress got=%0d exp>=150", naccept); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive_port(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    drive_port(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
    for (int i = 0; i < 40; i++) begin
      pre_idx  = IW'(i < 32 ? i : int'(DEPTH) - 40 + i);
      pre_data = {$urandom, $urandom};
      ref_mem[pre_idx] = pre_data;
      pre_we = 1'b1;
      tick;
    end
    pre_we = 1'b0;
    test_reset();
    test_store_load();
    test_errors();
    test_ld_during_cpu();
    test_reset_mid();
    test_contention();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
